// File: rtl/mii_uart_bridge.sv
// Bridges MII-domain bytes into a FIFO and drains them to a UART, either as raw
// bytes or as uppercase ASCII hex with CR/LF at each frame end.
module mii_uart_bridge #(
  parameter int DEPTH    = 128,
  parameter int HEX_MODE = 0,
  parameter int OVF_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_rdy,
  input  logic [7:0]               in_data,
  input  logic                     in_en,
  output logic                     tx_dv,
  output logic [7:0]               tx_byte,
  input  logic                     tx_active,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [OVF_W-1:0]         ovf_cnt,
  output logic [2:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO} state_t;

  // Handshake to the UART: tx_dv is a one-cycle start strobe with tx_byte valid
  // in the same cycle; it is only raised after tx_active has been seen low, and
  // the next character waits for a full tx_active high-then-low cycle.

  // [0],[1] synchroniser stages, [2] edge history
  logic [2:0] rdy_sync_q, rdy_sync_d;
  logic [2:0] en_sync_q, en_sync_d;
  logic       eof_pend_q, eof_pend_d;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [8:0]       mem_q [DEPTH];

  state_t     state_q;
  logic       tx_dv_q;
  logic [7:0] tx_byte_q;
  logic [4:0] hold_q;
  logic       more_q;

  logic       rdy_rise, en_fall;
  logic       push, push_ok, pop;
  logic [8:0] push_entry;
  logic [8:0] rd_entry;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign rdy_rise = rdy_sync_q[1] & ~rdy_sync_q[2];
  assign en_fall  = ~en_sync_q[1] & en_sync_q[2];
  assign pop      = (state_q == FETCH);
  assign push_ok  = push & (~full_q | pop);
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  // A data edge wins a tie with the frame end; the EOF is deferred one cycle.
  always_comb begin
    rdy_sync_d = {rdy_sync_q[1:0], in_rdy};
    en_sync_d  = {en_sync_q[1:0], in_en};
    push       = 1'b0;
    push_entry = 9'h000;
    eof_pend_d = eof_pend_q;
    if (rdy_rise) begin
      push       = 1'b1;
      push_entry = {1'b0, in_data};
      eof_pend_d = eof_pend_q | en_fall;
    end else if (eof_pend_q | en_fall) begin
      push       = 1'b1;
      push_entry = {1'b1, 8'h00};
      eof_pend_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (push && !push_ok && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_sync_q <= 3'b000;
      en_sync_q  <= 3'b000;
      eof_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= '0;
    end else begin
      rdy_sync_q <= rdy_sync_d;
      en_sync_q  <= en_sync_d;
      eof_pend_q <= eof_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  // hold_q keeps only what the second character needs: {eof, low nibble}.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      hold_q    <= 5'h00;
      more_q    <= 1'b0;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        IDLE: if (!empty_q && !tx_active) state_q <= FETCH;
        FETCH: begin
          hold_q <= {rd_entry[8], rd_entry[3:0]};
          if (rd_entry[8] && (HEX_MODE == 0)) begin
            state_q <= IDLE;
          end else begin
            state_q <= ISSUE;
            tx_dv_q <= 1'b1;
            if (HEX_MODE == 0) begin
              tx_byte_q <= rd_entry[7:0];
              more_q    <= 1'b0;
            end else if (rd_entry[8]) begin
              tx_byte_q <= 8'h0D;
              more_q    <= 1'b1;
            end else begin
              tx_byte_q <= hex_char(rd_entry[7:4]);
              more_q    <= 1'b1;
            end
          end
        end
        ISSUE: state_q <= WAIT_HI;
        WAIT_HI: if (tx_active) state_q <= WAIT_LO;
        WAIT_LO: begin
          if (!tx_active) begin
            if (more_q) begin
              more_q    <= 1'b0;
              tx_dv_q   <= 1'b1;
              tx_byte_q <= hold_q[4] ? 8'h0A : hex_char(hold_q[3:0]);
              state_q   <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign fifo_level = level_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign ovf_cnt    = ovf_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mii_uart_bridge.sv
// Bench: a raw-mode bridge (DEPTH=4, OVF_W=3) and a hex-mode bridge (DEPTH=128)
// share one MII stimulus stream; each has its own UART model and expected queue.
module tb_mii_uart_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_rdy = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_en = 1'b1;
  logic hold_tx = 1'b0;

  always #5 clk = ~clk;

  logic       raw_tx_dv, hex_tx_dv;
  logic [7:0] raw_tx_byte, hex_tx_byte;
  logic       raw_tx_active, hex_tx_active;
  logic [2:0] raw_level;
  logic [7:0] hex_level;
  logic       raw_full, raw_empty, hex_full, hex_empty;
  logic [2:0] raw_ovf;
  logic [7:0] hex_ovf;
  logic [2:0] raw_state, hex_state;

  mii_uart_bridge #(.DEPTH(4), .HEX_MODE(0), .OVF_W(3)) u_raw (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_data(in_data), .in_en(in_en),
    .tx_dv(raw_tx_dv), .tx_byte(raw_tx_byte), .tx_active(raw_tx_active),
    .fifo_level(raw_level), .fifo_full(raw_full), .fifo_empty(raw_empty),
    .ovf_cnt(raw_ovf), .state_dbg(raw_state));

  mii_uart_bridge #(.DEPTH(128), .HEX_MODE(1), .OVF_W(8)) u_hex (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_data(in_data), .in_en(in_en),
    .tx_dv(hex_tx_dv), .tx_byte(hex_tx_byte), .tx_active(hex_tx_active),
    .fifo_level(hex_level), .fifo_full(hex_full), .fifo_empty(hex_empty),
    .ovf_cnt(hex_ovf), .state_dbg(hex_state));

  // UART models: busy for a random 2..6 cycles after each start pulse.
  int busy_raw, busy_hex;
  always @(posedge clk) begin
    if (reset) busy_raw <= 0;
    else if (raw_tx_dv) busy_raw <= int'($urandom_range(2, 6));
    else if (busy_raw > 0) busy_raw <= busy_raw - 1;
  end
  always @(posedge clk) begin
    if (reset) busy_hex <= 0;
    else if (hex_tx_dv) busy_hex <= int'($urandom_range(2, 6));
    else if (busy_hex > 0) busy_hex <= busy_hex - 1;
  end
  assign raw_tx_active = hold_tx || (busy_raw != 0);
  assign hex_tx_active = hold_tx || (busy_hex != 0);

  logic [7:0] exp_raw_q[$];
  logic [7:0] exp_hex_q[$];
  int total = 0;
  int bad = 0;
  int raw_dv_n = 0;
  int hex_dv_n = 0;
  int raw_level_max = 0;
  int ovf_exp = 0;

  // Scoreboard: every start pulse must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (int'(raw_level) > raw_level_max) raw_level_max = int'(raw_level);
      if (raw_tx_dv) begin
        raw_dv_n++;
        total++;
        if (raw_tx_active) begin
          bad++;
          $display("FAIL raw_dv_while_busy: tx_active=%b required 0", raw_tx_active);
        end
        total++;
        if (exp_raw_q.size() == 0) begin
          bad++;
          $display("FAIL raw_unexpected: got %h, required no character", raw_tx_byte);
        end else begin
          logic [7:0] e;
          e = exp_raw_q.pop_front();
          if (raw_tx_byte !== e) begin
            bad++;
            $display("FAIL raw_char: got %h required %h", raw_tx_byte, e);
          end
        end
      end
      if (hex_tx_dv) begin
        hex_dv_n++;
        total++;
        if (hex_tx_active) begin
          bad++;
          $display("FAIL hex_dv_while_busy: tx_active=%b required 0", hex_tx_active);
        end
        total++;
        if (exp_hex_q.size() == 0) begin
          bad++;
          $display("FAIL hex_unexpected: got %h, required no character", hex_tx_byte);
        end else begin
          logic [7:0] e;
          e = exp_hex_q.pop_front();
          if (hex_tx_byte !== e) begin
            bad++;
            $display("FAIL hex_char: got %h required %h", hex_tx_byte, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  task automatic model_data(input logic [7:0] b, input bit raw_ok);
    if (raw_ok) exp_raw_q.push_back(b);
    else if (ovf_exp < 7) ovf_exp++;
    exp_hex_q.push_back(hex_ch(b[7:4]));
    exp_hex_q.push_back(hex_ch(b[3:0]));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit raw_ok, input int gap_lo, input int gap_hi);
    model_data(b, raw_ok);
    @(negedge clk);
    in_data = b;
    in_rdy  = 1'b1;
    repeat ($urandom_range(3, 5)) @(negedge clk);
    in_rdy = 1'b0;
    repeat ($urandom_range(gap_lo, gap_hi)) @(negedge clk);
  endtask

  task automatic end_frame;
    exp_hex_q.push_back(8'h0D);
    exp_hex_q.push_back(8'h0A);
    @(negedge clk);
    in_en = 1'b0;
    repeat (4) @(negedge clk);
    in_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_raw_q.size() != 0 || exp_hex_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 5000) begin
      bad++;
      $display("FAIL %s_drain: raw_left=%0d hex_left=%0d required 0", tag, exp_raw_q.size(), exp_hex_q.size());
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total += 12;
    if (raw_tx_dv !== 1'b0)   begin bad++; $display("FAIL rst_raw_dv: got %b required 0", raw_tx_dv); end
    if (raw_tx_byte !== 8'h0) begin bad++; $display("FAIL rst_raw_byte: got %h required 00", raw_tx_byte); end
    if (raw_level !== 3'd0)   begin bad++; $display("FAIL rst_raw_level: got %0d required 0", raw_level); end
    if (raw_empty !== 1'b1)   begin bad++; $display("FAIL rst_raw_empty: got %b required 1", raw_empty); end
    if (raw_full !== 1'b0)    begin bad++; $display("FAIL rst_raw_full: got %b required 0", raw_full); end
    if (raw_ovf !== 3'd0)     begin bad++; $display("FAIL rst_raw_ovf: got %0d required 0", raw_ovf); end
    if (hex_tx_dv !== 1'b0)   begin bad++; $display("FAIL rst_hex_dv: got %b required 0", hex_tx_dv); end
    if (hex_tx_byte !== 8'h0) begin bad++; $display("FAIL rst_hex_byte: got %h required 00", hex_tx_byte); end
    if (hex_level !== 8'd0)   begin bad++; $display("FAIL rst_hex_level: got %0d required 0", hex_level); end
    if (hex_empty !== 1'b1)   begin bad++; $display("FAIL rst_hex_empty: got %b required 1", hex_empty); end
    if (hex_full !== 1'b0)    begin bad++; $display("FAIL rst_hex_full: got %b required 0", hex_full); end
    if (hex_ovf !== 8'd0)     begin bad++; $display("FAIL rst_hex_ovf: got %0d required 0", hex_ovf); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_raw_basic;
    send_byte(8'h12, 1'b1, 6, 8);
    send_byte(8'h34, 1'b1, 6, 8);
    send_byte(8'h56, 1'b1, 6, 8);
    wait_drain("raw_basic");
    total += 3;
    if (raw_ovf !== 3'd0)      begin bad++; $display("FAIL raw_basic_ovf: got %0d required 0", raw_ovf); end
    if (raw_tx_byte !== 8'h56) begin bad++; $display("FAIL raw_basic_held: got %h required 56", raw_tx_byte); end
    if (raw_empty !== 1'b1)    begin bad++; $display("FAIL raw_basic_empty: got %b required 1", raw_empty); end
  endtask

  task automatic test_hex_frame;
    send_byte(8'hA5, 1'b1, 4, 6);
    end_frame();
    wait_drain("hex_frame");
    total += 2;
    if (hex_empty !== 1'b1)    begin bad++; $display("FAIL hex_frame_empty: got %b required 1", hex_empty); end
    if (hex_tx_byte !== 8'h0A) begin bad++; $display("FAIL hex_frame_held: got %h required 0a", hex_tx_byte); end
  endtask

  task automatic test_simultaneous;
    model_data(8'h0F, 1'b1);
    exp_hex_q.push_back(8'h0D);
    exp_hex_q.push_back(8'h0A);
    @(negedge clk);
    in_data = 8'h0F;
    in_rdy  = 1'b1;
    in_en   = 1'b0;
    repeat (4) @(negedge clk);
    in_rdy = 1'b0;
    in_en  = 1'b1;
    wait_drain("simul");
    total += 2;
    if (raw_tx_byte !== 8'h0F) begin bad++; $display("FAIL simul_raw_held: got %h required 0f", raw_tx_byte); end
    if (hex_empty !== 1'b1)    begin bad++; $display("FAIL simul_hex_empty: got %b required 1", hex_empty); end
  endtask

  // Two synchroniser stages plus three cycles of push-to-strobe latency.
  task automatic test_latency;
    int lat_r, lat_h;
    logic [7:0] b;
    lat_r = 0;
    lat_h = 0;
    b = 8'($urandom_range(0, 255));
    model_data(b, 1'b1);
    @(negedge clk);
    in_data = b;
    in_rdy  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (raw_tx_dv && lat_r == 0) lat_r = i;
      if (hex_tx_dv && lat_h == 0) lat_h = i;
    end
    in_rdy = 1'b0;
    total += 2;
    if (lat_r != 5) begin bad++; $display("FAIL raw_latency: got %0d cycles required 5", lat_r); end
    if (lat_h != 5) begin bad++; $display("FAIL hex_latency: got %0d cycles required 5", lat_h); end
    wait_drain("latency");
  endtask

  task automatic test_wrap;
    raw_level_max = 0;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1, 10, 14);
      if ($urandom_range(0, 3) == 0) end_frame();
    end
    wait_drain("wrap");
    total += 3;
    if (raw_level_max > 4) begin bad++; $display("FAIL wrap_level: max %0d required <= 4", raw_level_max); end
    if (raw_ovf !== 3'd0)  begin bad++; $display("FAIL wrap_ovf: got %0d required 0", raw_ovf); end
    if (raw_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b required 1", raw_empty); end
  endtask

  task automatic test_overflow;
    hold_tx = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), (i < 4), 3, 5);
    total += 5;
    if (raw_full !== 1'b1)            begin bad++; $display("FAIL ovf_full: got %b required 1", raw_full); end
    if (raw_level !== 3'd4)           begin bad++; $display("FAIL ovf_level: got %0d required 4", raw_level); end
    if (int'(raw_ovf) != ovf_exp)     begin bad++; $display("FAIL ovf_count: got %0d required %0d", raw_ovf, ovf_exp); end
    if (hex_level !== 8'd6)           begin bad++; $display("FAIL ovf_hex_level: got %0d required 6", hex_level); end
    if (hex_full !== 1'b0)            begin bad++; $display("FAIL ovf_hex_full: got %b required 0", hex_full); end
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 3, 5);
    total += 3;
    if (int'(raw_ovf) != ovf_exp)     begin bad++; $display("FAIL ovf_saturate: got %0d required %0d", raw_ovf, ovf_exp); end
    if (raw_level !== 3'd4)           begin bad++; $display("FAIL ovf_level2: got %0d required 4", raw_level); end
    if (hex_level !== 8'd13)          begin bad++; $display("FAIL ovf_hex_level2: got %0d required 13", hex_level); end
    hold_tx = 1'b0;
    wait_drain("ovf");
    total += 2;
    if (int'(raw_ovf) != ovf_exp)     begin bad++; $display("FAIL ovf_after: got %0d required %0d", raw_ovf, ovf_exp); end
    if (raw_empty !== 1'b1)           begin bad++; $display("FAIL ovf_empty: got %b required 1", raw_empty); end
  endtask

  task automatic test_reset_mid;
    int n0, n_r, n_h, t;
    n0 = hex_dv_n;
    model_data(8'h3C, 1'b1);
    model_data(8'h7E, 1'b1);
    @(negedge clk);
    in_data = 8'h3C;
    in_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    in_rdy = 1'b0;
    @(negedge clk);
    in_data = 8'h7E;
    in_rdy  = 1'b1;
    t = 0;
    while (hex_dv_n < n0 + 2 && t < 300) begin
      @(negedge clk);
      t++;
    end
    in_rdy = 1'b0;
    total++;
    if (t >= 300) begin bad++; $display("FAIL mid_wait: hex pulses %0d required %0d", hex_dv_n - n0, 2); end
    repeat (2) @(negedge clk);
    total++;
    if (hex_empty !== 1'b0) begin bad++; $display("FAIL mid_pre_empty: got %b required 0", hex_empty); end
    reset = 1'b1;
    exp_raw_q.delete();
    exp_hex_q.delete();
    ovf_exp = 0;
    @(negedge clk);
    total += 6;
    if (hex_empty !== 1'b1) begin bad++; $display("FAIL mid_hex_empty: got %b required 1", hex_empty); end
    if (hex_ovf !== 8'd0)   begin bad++; $display("FAIL mid_hex_ovf: got %0d required 0", hex_ovf); end
    if (hex_tx_dv !== 1'b0) begin bad++; $display("FAIL mid_hex_dv: got %b required 0", hex_tx_dv); end
    if (raw_empty !== 1'b1) begin bad++; $display("FAIL mid_raw_empty: got %b required 1", raw_empty); end
    if (raw_ovf !== 3'd0)   begin bad++; $display("FAIL mid_raw_ovf: got %0d required 0", raw_ovf); end
    if (raw_tx_dv !== 1'b0) begin bad++; $display("FAIL mid_raw_dv: got %b required 0", raw_tx_dv); end
    reset = 1'b0;
    n_r = raw_dv_n;
    n_h = hex_dv_n;
    repeat (30) @(negedge clk);
    total += 2;
    if (raw_dv_n != n_r) begin bad++; $display("FAIL mid_raw_quiet: got %0d pulses required 0", raw_dv_n - n_r); end
    if (hex_dv_n != n_h) begin bad++; $display("FAIL mid_hex_quiet: got %0d pulses required 0", hex_dv_n - n_h); end
    send_byte(8'h9B, 1'b1, 4, 6);
    wait_drain("post_reset");
    total++;
    if (hex_tx_byte !== 8'h42) begin bad++; $display("FAIL post_reset_hex: got %h required 42", hex_tx_byte); end
  endtask

  initial begin
    test_reset();
    test_raw_basic();
    test_hex_frame();
    test_simultaneous();
    test_latency();
    test_wrap();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mii_uart_bridge.md
Name: mii_uart_bridge

Overview:
- Parametrised successor to the single-channel MII-to-UART path.
- Captures bytes from an MII receiver running in a foreign clock domain and queues them in a parametrised FIFO, with frame-end markers and overflow accounting.
- Drains the FIFO into a UART transmitter, either as raw bytes or as ASCII hex with CR/LF at each frame end.
- Sits between the MII byte assembler and the uart_tx instance in the top level.

Parameters:
- DEPTH, 128, FIFO entries; power of 2, minimum 4.
- HEX_MODE, 0, 0 = raw bytes; 1 = two uppercase ASCII hex chars per byte plus CR,LF per frame.
- OVF_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_rdy  in  1  byte-ready level from the MII clock domain; high for at least 3 clk periods per byte
- in_data  in  8  byte; stable while in_rdy is high
- in_en  in  1  MII frame-active level, asynchronous to clk
- tx_dv  out  1  one-cycle start pulse to the UART
- tx_byte  out  8  character to send; held until the next tx_dv
- tx_active  in  1  UART busy flag
- fifo_level  out  clog2(DEPTH)+1  current occupancy
- fifo_full  out  1  occupancy == DEPTH
- fifo_empty  out  1  occupancy == 0
- ovf_cnt  out  OVF_W  dropped entries, saturating

Behaviour:
- Reset values: tx_dv=0, tx_byte=0, fifo_level=0, fifo_empty=1, fifo_full=0, ovf_cnt=0. Reset also clears pointers, synchroniser flops and the FSM (to IDLE). Reset mid-transmission abandons the current character sequence; no further tx_dv until after reset.
- Input synchronisation: in_rdy and in_en each pass through a 2-flop synchroniser plus an edge-history flop.
  - Push a data entry {0,in_data} on the synchronised rising edge of in_rdy. in_data is sampled directly; it is stable by then.
  - Push an EOF entry {1,8'h00} on the synchronised falling edge of in_en.
  - If both edges occur in the same cycle, push the data entry; the EOF entry is pushed the next cycle.
- FIFO: 9-bit entries; write/read pointers are clog2(DEPTH)+1 bits and wrap naturally.
  - full when pointers differ only in the MSB; empty when equal.
  - Push while full drops the entry (data or EOF) and increments ovf_cnt, saturating at all-ones.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and fifo_level is unchanged.
- TX FSM states: IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE: if not empty and tx_active==0, go to FETCH.
  - FETCH: pop one entry into a holding register and build the character list:
    - raw mode, data entry: the byte.
    - raw mode, EOF entry: nothing; return to IDLE.
    - hex mode, data entry: hex(hi nibble), then hex(lo nibble), with 0-9 → 8'h30-8'h39 and A-F → 8'h41-8'h46.
    - hex mode, EOF entry: 8'h0D, then 8'h0A.
  - ISSUE: drive tx_byte with the current character and pulse tx_dv for exactly 1 cycle; go to WAIT_HI.
  - WAIT_HI: wait for tx_active==1.
  - WAIT_LO: wait for tx_active==0. If more characters remain in the list, go to ISSUE; otherwise go to IDLE.
- Ordering and timing:
  - Characters are emitted strictly in FIFO order with no interleaving.
  - tx_dv is never asserted while tx_active==1.
  - Minimum latency from push to tx_dv is 3 clk cycles, with the FIFO empty and the UART idle.
- fifo_level, fifo_full and fifo_empty are registered and reflect the state after the current cycle's push/pop.

Test Plan:
- Raw mode, DEPTH=128: send bytes 8'h12, 8'h34, 8'h56 with in_en high → tx_byte sequence 12,34,56, one tx_dv each, each pulse only after tx_active falls; ovf_cnt=0.
- Hex mode: byte 8'hA5, then in_en falls → characters 8'h41, 8'h35, 8'h0D, 8'h0A in order; fifo_empty=1 at the end.
- Overflow, DEPTH=4, tx_active held high: push 6 bytes → fifo_full=1, fifo_level=4, ovf_cnt=2; release tx_active → the first 4 bytes come out in order.
- Wrap-around, DEPTH=4: stream 10 bytes while the UART model drains continuously → all 10 are received in order; fifo_level never exceeds 4; ovf_cnt=0.
- Reset mid-operation: assert reset during WAIT_LO of the second hex character → the next cycle shows fifo_empty=1, ovf_cnt=0, tx_dv=0; no tx_dv until new input arrives.
- Simultaneous edges: in_rdy rising and in_en falling synchronised in the same cycle (hex mode, byte 8'h0F) → characters 8'h30, 8'h46, 8'h0D, 8'h0A.
